controle_jogo_sequencias: RTL and testbench
===========================================

Name: controle_jogo_sequencias

Overview:
- Moore FSM controlling the sequence-game datapath (counters E/L, jogada register, timeout counter, LED output).
- Each round first plays the current sequence (addresses 0..L) on the LEDs, using an internal on/off display timer.
- Then collects and compares the player's moves, and decides win, loss or timeout.
- Sits beside fluxo_dados in the next experiment's top level and replaces the plain unidade_controle.

Parameters:
- T_MOSTRA, 1000: clock cycles an LED stays lit per sequence element during display (bench uses 4).
- T_APAGA, 250: clock cycles LEDs stay dark between displayed elements (bench uses 2).
- LIMITE_FACIL, 7: limit value that ends the game when nivel=0 (8 rounds); nivel=1 ends at fimL (16 rounds).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request (level, held ≥1 cycle)
- nivel  in  1  difficulty; sampled in preparacao only
- fimE  in  1  address counter E at terminal count (debug only, no effect on transitions)
- fimL  in  1  limit counter L at terminal count (15)
- limite  in  4  current value of counter L
- enderecoIgualLimite  in  1  E == L
- jogada  in  1  one-cycle pulse: player pressed a button (edge-detected in datapath)
- igual  in  1  registered jogada == memory[E]
- timeout  in  1  timeout counter expired
- zeraE, contaE  out  1  clear/increment counter E
- zeraL, contaL  out  1  clear/increment counter L
- zeraR, registraR  out  1  clear/load jogada register
- zeraT, contaT  out  1  clear/enable timeout counter
- mostra_leds  out  1  1 = LEDs drive memory[E]; 0 = LEDs driven by jogada register
- ganhou, perdeu, pronto  out  1  game result flags
- db_estado  out  4  state code for hexa7seg

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high; it applies at any state, including mid-display or mid-play, and overrides iniciar. On reset, state = inicial (0x0), the display timer is cleared, nivel_r = 0, and every output is 0.
- Outputs: all outputs are a combinational decode of the state register only (Moore). Control pulses last exactly one cycle per visit to their state.
- Display timer: internal counter of width ceil(log2(max(T_MOSTRA, T_APAGA))). It counts only in mostra and apaga, and clears on every transition out of those states.
- States, codes and transitions:
  - inicial 0x0: no outputs asserted. iniciar -> preparacao.
  - preparacao 0x1: zeraE, zeraL, zeraR, zeraT; nivel_r <= nivel. Next state mostra.
  - mostra 0x2: mostra_leds=1. When timer == T_MOSTRA-1 -> apaga.
  - apaga 0x3: mostra_leds=0. When timer == T_APAGA-1: if enderecoIgualLimite -> inicio_rodada, else -> proximo_mostra.
  - proximo_mostra 0x4: contaE. Next state mostra.
  - inicio_rodada 0x5: zeraE, zeraR, zeraT. Next state espera_jogada.
  - espera_jogada 0x6: contaT. jogada -> registra. Else timeout -> fim_timeout (see Optional Feature). If both occur in the same cycle, jogada wins.
  - registra 0x7: registraR. Next state comparacao.
  - comparacao 0x8, evaluated in priority order:
    - !igual -> fim_errou.
    - !enderecoIgualLimite -> proxima_jogada.
    - last round -> fim_acertou. Last round is (nivel_r ? fimL : limite == LIMITE_FACIL).
    - otherwise -> proxima_rodada.
  - proxima_jogada 0x9: contaE, zeraT. Next state espera_jogada.
  - proxima_rodada 0xB: contaL, zeraE. Next state mostra.
  - fim_acertou 0xA: ganhou=1, pronto=1.
  - fim_errou 0xE: perdeu=1, pronto=1.
  - fim_timeout 0xD: perdeu=1, pronto=1.
  - All three final states hold their outputs. iniciar -> preparacao, restarting the game directly.
- Unused codes (0xC, 0xF) -> inicial on the next clock.
- Ignored inputs: iniciar is ignored outside inicial and the final states. jogada is ignored outside espera_jogada; a button pressed during display is not registered.
- Round timing: round L displays L+1 elements, taking (L+1)·(T_MOSTRA+T_APAGA) + L cycles before inicio_rodada.
- nivel changes after preparacao have no effect until the next game.

Optional Feature:
- Macro CONTROLE_TIMEOUT_EN.
- Defined: timeout in espera_jogada -> fim_timeout (0xD); contaT and zeraT are driven as specified.
- Undefined: the timeout input is ignored, fim_timeout is unreachable (0xD -> inicial if ever reached), and contaT/zeraT are tied to 0.

Test Plan:
- Reset then idle: after reset, db_estado=0x0 and all outputs 0. Assert reset in state 0x6 -> state 0x0 next cycle, ganhou=perdeu=pronto=0.
- Display round 0, T_MOSTRA=4, T_APAGA=2, enderecoIgualLimite=1:
  - iniciar -> 0x1 for 1 cycle.
  - mostra_leds=1 for exactly 4 cycles, then 0 for 2 cycles.
  - Then 0x5 followed by 0x6.
- Correct play, nivel=0: drive correct jogada/igual through rounds L=0..7.
  - ganhou=1 and pronto=1 in 0xA after round 7 comparacao.
  - contaL pulsed exactly 7 times; contaE pulsed once per non-final move.
- Wrong move: in round 2, second move, igual=0 at comparacao -> state 0xE, perdeu=1, pronto=1. A following iniciar -> 0x1 with zeraE, zeraL, zeraR all 1.
- Timeout with CONTROLE_TIMEOUT_EN:
  - timeout=1 in 0x6 -> 0xD with perdeu=1.
  - timeout and jogada in the same cycle -> 0x7.
  - Without the macro, timeout held high keeps the FSM in 0x6 with contaT=0.
- nivel=1: no win at limite=7. Game continues until fimL=1 at comparacao with E==L -> 0xA. Toggling nivel mid-game changes nothing.

Source files
------------

// File: rtl/controle_jogo_sequencias_if.sv
`default_nettype none
// ============================================================================
// Module   : controle_jogo_sequencias_if
// Brief    : Control/status bundle between the sequence-game controller and
//            its datapath (fluxo_dados).
// Revision : 1.0 - initial release
// ============================================================================
interface controle_jogo_sequencias_if;
    // datapath -> controller
    logic       iniciar;
    logic       nivel;
    logic       fimE;
    logic       fimL;
    logic [3:0] limite;
    logic       enderecoIgualLimite;
    logic       jogada;
    logic       igual;
    logic       timeout;
    // controller -> datapath
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       zeraT;
    logic       contaT;
    logic       mostra_leds;
    logic       ganhou;
    logic       perdeu;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, nivel, fimE, fimL, limite, enderecoIgualLimite,
               jogada, igual, timeout,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               mostra_leds, ganhou, perdeu, pronto, db_estado
    );

    modport slave (
        output iniciar, nivel, fimE, fimL, limite, enderecoIgualLimite,
               jogada, igual, timeout,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               mostra_leds, ganhou, perdeu, pronto, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/controle_jogo_sequencias.sv
`default_nettype none
// ============================================================================
// Module   : controle_jogo_sequencias
// Brief    : Moore controller for the sequence game: plays the sequence on the
//            LEDs, collects the player's moves and decides win/loss/timeout.
//            Optional feature macro: CONTROLE_TIMEOUT_EN (timeout -> loss).
// Revision : 1.0 - initial release
// ============================================================================
module controle_jogo_sequencias #(
    parameter int T_MOSTRA     = 1000,
    parameter int T_APAGA      = 250,
    parameter int LIMITE_FACIL = 7
) (
    input  logic                              clock,
    input  logic                              reset,
    controle_jogo_sequencias_if.master        bus
);

    localparam int C_T_MAX = (T_MOSTRA > T_APAGA) ? T_MOSTRA : T_APAGA;
    localparam int TW      = (C_T_MAX > 1) ? $clog2(C_T_MAX) : 1;

    localparam logic [TW-1:0] C_FIM_MOSTRA    = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0] C_FIM_APAGA     = TW'(T_APAGA - 1);
    localparam logic [3:0]    C_LIMITE_FACIL  = 4'(LIMITE_FACIL);

    localparam logic [3:0] S_INICIAL        = 4'h0;
    localparam logic [3:0] S_PREPARACAO     = 4'h1;
    localparam logic [3:0] S_MOSTRA         = 4'h2;
    localparam logic [3:0] S_APAGA          = 4'h3;
    localparam logic [3:0] S_PROXIMO_MOSTRA = 4'h4;
    localparam logic [3:0] S_INICIO_RODADA  = 4'h5;
    localparam logic [3:0] S_ESPERA_JOGADA  = 4'h6;
    localparam logic [3:0] S_REGISTRA       = 4'h7;
    localparam logic [3:0] S_COMPARACAO     = 4'h8;
    localparam logic [3:0] S_PROXIMA_JOGADA = 4'h9;
    localparam logic [3:0] S_FIM_ACERTOU    = 4'hA;
    localparam logic [3:0] S_PROXIMA_RODADA = 4'hB;
    localparam logic [3:0] S_FIM_TIMEOUT    = 4'hD;
    localparam logic [3:0] S_FIM_ERROU      = 4'hE;

    logic [3:0]    estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          nivel_q, nivel_d;
    logic          ultima_rodada;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= S_INICIAL;
            timer_q  <= '0;
            nivel_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            nivel_q  <= nivel_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d      = estado_q;
        ultima_rodada = nivel_q ? bus.fimL : (bus.limite == C_LIMITE_FACIL);
        case (estado_q)
            S_INICIAL:        if (bus.iniciar) estado_d = S_PREPARACAO;
            S_PREPARACAO:     estado_d = S_MOSTRA;
            S_MOSTRA:         if (timer_q == C_FIM_MOSTRA) estado_d = S_APAGA;
            S_APAGA: begin
                if (timer_q == C_FIM_APAGA)
                    estado_d = bus.enderecoIgualLimite ? S_INICIO_RODADA
                                                       : S_PROXIMO_MOSTRA;
            end
            S_PROXIMO_MOSTRA: estado_d = S_MOSTRA;
            S_INICIO_RODADA:  estado_d = S_ESPERA_JOGADA;
            S_ESPERA_JOGADA: begin
                // A button press in the same cycle as the timeout still counts.
                if (bus.jogada)
                    estado_d = S_REGISTRA;
`ifdef CONTROLE_TIMEOUT_EN
                else if (bus.timeout)
                    estado_d = S_FIM_TIMEOUT;
`endif
            end
            S_REGISTRA:       estado_d = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!bus.igual)                    estado_d = S_FIM_ERROU;
                else if (!bus.enderecoIgualLimite) estado_d = S_PROXIMA_JOGADA;
                else if (ultima_rodada)            estado_d = S_FIM_ACERTOU;
                else                               estado_d = S_PROXIMA_RODADA;
            end
            S_PROXIMA_JOGADA: estado_d = S_ESPERA_JOGADA;
            S_PROXIMA_RODADA: estado_d = S_MOSTRA;
            S_FIM_ACERTOU,
            S_FIM_ERROU:      if (bus.iniciar) estado_d = S_PREPARACAO;
`ifdef CONTROLE_TIMEOUT_EN
            S_FIM_TIMEOUT:    if (bus.iniciar) estado_d = S_PREPARACAO;
`endif
            default:          estado_d = S_INICIAL;
        endcase

        // Display timer runs only while dwelling in mostra/apaga.
        timer_d = '0;
        if (((estado_q == S_MOSTRA) || (estado_q == S_APAGA)) && (estado_d == estado_q))
            timer_d = timer_q + 1'b1;

        nivel_d = (estado_q == S_PREPARACAO) ? bus.nivel : nivel_q;
    end

    // ------------------------------------------------------------------
    // Output decode (state only)
    // ------------------------------------------------------------------
    always_comb begin
        bus.zeraE       = 1'b0;
        bus.contaE      = 1'b0;
        bus.zeraL       = 1'b0;
        bus.contaL      = 1'b0;
        bus.zeraR       = 1'b0;
        bus.registraR   = 1'b0;
        bus.zeraT       = 1'b0;
        bus.contaT      = 1'b0;
        bus.mostra_leds = 1'b0;
        bus.ganhou      = 1'b0;
        bus.perdeu      = 1'b0;
        bus.pronto      = 1'b0;
        bus.db_estado   = estado_q;
        case (estado_q)
            S_PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
`ifdef CONTROLE_TIMEOUT_EN
                bus.zeraT = 1'b1;
`endif
            end
            S_MOSTRA:         bus.mostra_leds = 1'b1;
            S_PROXIMO_MOSTRA: bus.contaE      = 1'b1;
            S_INICIO_RODADA: begin
                bus.zeraE = 1'b1;
                bus.zeraR = 1'b1;
`ifdef CONTROLE_TIMEOUT_EN
                bus.zeraT = 1'b1;
`endif
            end
            S_ESPERA_JOGADA: begin
`ifdef CONTROLE_TIMEOUT_EN
                bus.contaT = 1'b1;
`endif
            end
            S_REGISTRA:       bus.registraR = 1'b1;
            S_PROXIMA_JOGADA: begin
                bus.contaE = 1'b1;
`ifdef CONTROLE_TIMEOUT_EN
                bus.zeraT  = 1'b1;
`endif
            end
            S_PROXIMA_RODADA: begin
                bus.contaL = 1'b1;
                bus.zeraE  = 1'b1;
            end
            S_FIM_ACERTOU: begin
                bus.ganhou = 1'b1;
                bus.pronto = 1'b1;
            end
            S_FIM_ERROU: begin
                bus.perdeu = 1'b1;
                bus.pronto = 1'b1;
            end
`ifdef CONTROLE_TIMEOUT_EN
            S_FIM_TIMEOUT: begin
                bus.perdeu = 1'b1;
                bus.pronto = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_jogo_sequencias.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_jogo_sequencias
// Brief    : Self-checking bench: scripted games with random player timing,
//            expected state/output trace built from the game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_jogo_sequencias;

    localparam int T_MOSTRA = 4;
    localparam int T_APAGA  = 2;
`ifdef CONTROLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    controle_jogo_sequencias_if bus ();

    controle_jogo_sequencias #(
        .T_MOSTRA     (T_MOSTRA),
        .T_APAGA      (T_APAGA),
        .LIMITE_FACIL (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // One entry per clock cycle: the inputs driven during it and the state expected.
    typedef struct packed {
        logic [7:0] game;
        logic       rst;
        logic       ini;
        logic       niv;
        logic       jog;
        logic       igu;
        logic       tmo;
        logic [3:0] e;
        logic [3:0] l;
        logic [3:0] st;
    } ent_t;

    ent_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cur_i  = 0;
    logic [3:0] e_idx, l_idx, last_final;
    logic       game_niv;
    bit         toggle_niv, ended_idle;
    logic [7:0] gid;

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    // Output vector order: zeraE contaE zeraL contaL zeraR registraR zeraT contaT
    //                      mostra_leds ganhou perdeu pronto
    function automatic logic [11:0] exp_out(input logic [3:0] st);
        logic [11:0] o;
        case (st)
            4'h1:    o = 12'hAA0;
            4'h2:    o = 12'h008;
            4'h4:    o = 12'h400;
            4'h5:    o = 12'h8A0;
            4'h6:    o = 12'h010;
            4'h7:    o = 12'h040;
            4'h9:    o = 12'h420;
            4'hB:    o = 12'h900;
            4'hA:    o = 12'h005;
            4'hD,
            4'hE:    o = 12'h003;
            default: o = 12'h000;
        endcase
        if (!TMO_EN) o = o & ~12'h030;
        return o;
    endfunction

    function automatic logic [11:0] act_out();
        return {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR,
                bus.zeraT, bus.contaT, bus.mostra_leds, bus.ganhou, bus.perdeu, bus.pronto};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (cycle entry %0d): got %h expected %h", nm, cur_i, act, expv);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic ini, input logic jog,
                        input logic igu, input logic tmo, input logic rst);
        ent_t x;
        x.game = gid;
        x.rst  = rst;
        x.ini  = ini;
        x.niv  = (st == 4'h1 || !toggle_niv) ? game_niv : rb();
        x.jog  = jog;
        x.igu  = igu;
        x.tmo  = tmo;
        x.e    = e_idx;
        x.l    = l_idx;
        x.st   = st;
        q.push_back(x);
    endtask

    task automatic finish_game(input logic [3:0] fs);
        int h;
        last_final = fs;
        ended_idle = 1'b0;
        h = $urandom_range(1, 3);
        for (int i = 0; i < h; i++) push(fs, 1'b0, rb(), rb(), rb(), 1'b0);
        gid++;
    endtask

    // Appends one game. fail_r/fail_m: round/move answered wrong; tmo_r: round whose
    // first move times out; rst_r: round whose first move is cut by reset (-1 = none).
    task automatic build_game(input logic niv, input int fail_r, input int fail_m,
                              input int tmo_r, input int rst_r, input bit tog);
        int nw;
        game_niv   = niv;
        toggle_niv = 1'b0;
        if (ended_idle) begin
            nw = $urandom_range(0, 2);
            for (int i = 0; i < nw; i++) push(4'h0, 1'b0, rb(), rb(), rb(), 1'b0);
            push(4'h0, 1'b1, rb(), rb(), rb(), 1'b0);
        end else begin
            push(last_final, 1'b1, rb(), rb(), rb(), 1'b0);
        end
        push(4'h1, rb(), rb(), rb(), rb(), 1'b0);
        toggle_niv = tog;
        for (int l = 0; l < 16; l++) begin
            l_idx = 4'(l);
            for (int e = 0; e <= l; e++) begin
                e_idx = 4'(e);
                for (int k = 0; k < T_MOSTRA; k++) push(4'h2, rb(), rb(), rb(), rb(), 1'b0);
                for (int k = 0; k < T_APAGA; k++)  push(4'h3, rb(), rb(), rb(), rb(), 1'b0);
                if (e < l) push(4'h4, rb(), rb(), rb(), rb(), 1'b0);
            end
            push(4'h5, rb(), rb(), rb(), rb(), 1'b0);
            for (int m = 0; m <= l; m++) begin
                e_idx = 4'(m);
                if (l == rst_r && m == 0) begin
                    push(4'h6, 1'b1, rb(), rb(), rb(), 1'b1);
                    ended_idle = 1'b1;
                    gid++;
                    return;
                end
                nw = $urandom_range(0, 3);
                for (int i = 0; i < nw; i++)
                    push(4'h6, rb(), 1'b0, rb(), TMO_EN ? 1'b0 : 1'b1, 1'b0);
                if (TMO_EN && l == tmo_r && m == 0) begin
                    push(4'h6, rb(), 1'b0, rb(), 1'b1, 1'b0);
                    finish_game(4'hD);
                    return;
                end
                push(4'h6, rb(), 1'b1, rb(), rb(), 1'b0);
                push(4'h7, rb(), rb(), rb(), rb(), 1'b0);
                if (l == fail_r && m == fail_m) begin
                    push(4'h8, rb(), rb(), 1'b0, rb(), 1'b0);
                    finish_game(4'hE);
                    return;
                end
                push(4'h8, rb(), rb(), 1'b1, rb(), 1'b0);
                if (m < l) push(4'h9, rb(), rb(), rb(), rb(), 1'b0);
            end
            if (niv ? (l == 15) : (l == 7)) begin
                finish_game(4'hA);
                return;
            end
            push(4'hB, rb(), rb(), rb(), rb(), 1'b0);
        end
    endtask

    initial begin
        ent_t x;
        int   n_b, n_2, n_3, n_ce, dut_ce, dut_cl;
        bit   seen5;
        int   fr;

        ended_idle = 1'b1;
        gid        = 8'd0;
        e_idx      = 4'd0;
        l_idx      = 4'd0;
        last_final = 4'h0;
        game_niv   = 1'b0;
        toggle_niv = 1'b0;

        build_game(1'b0, -1, -1, -1, -1, 1'b0);                   // full easy win
        build_game(1'b0,  2,  1, -1, -1, 1'b0);                   // wrong 2nd move, round 2
        build_game(1'b1, -1, -1, -1, -1, 1'b1);                   // hard win, nivel toggling
        build_game(1'b0, TMO_EN ? -1 : 3, 0, 1, -1, 1'b1);        // timeout (or late miss)
        build_game(rb(), -1, -1, -1,  2, 1'b0);                   // reset while waiting
        for (int g = 0; g < 5; g++) begin
            fr = $urandom_range(0, 9);
            build_game(rb(), fr, $urandom_range(0, fr),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1,
                       -1, 1'(g % 2));
        end

        // Hand-computed properties of the easy-win game pin the trace builder.
        n_b = 0; n_2 = 0; n_3 = 0; n_ce = 0; seen5 = 1'b0;
        foreach (q[i]) begin
            if (q[i].game == 8'd0) begin
                if (q[i].st == 4'hB) n_b++;
                if (q[i].st == 4'h4 || q[i].st == 4'h9) n_ce++;
                if (q[i].st == 4'h5) seen5 = 1'b1;
                if (!seen5 && q[i].st == 4'h2) n_2++;
                if (!seen5 && q[i].st == 4'h3) n_3++;
            end
        end
        chk("model_rounds_easy", 16'(n_b), 16'd7);
        chk("model_contaE_easy", 16'(n_ce), 16'd56);
        chk("model_mostra_r0", 16'(n_2), 16'd4);
        chk("model_apaga_r0", 16'(n_3), 16'd2);

        bus.iniciar = 1'b0; bus.nivel = 1'b0; bus.fimE = 1'b0; bus.fimL = 1'b0;
        bus.limite = 4'd0; bus.enderecoIgualLimite = 1'b0; bus.jogada = 1'b0;
        bus.igual = 1'b0; bus.timeout = 1'b0;
        reset = 1'b1;
        bus.iniciar = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {12'h000, bus.db_estado}, 16'h0000);
        chk("reset_outputs", {4'h0, act_out()}, 16'h0000);

        dut_ce = 0;
        dut_cl = 0;
        for (int i = 0; i < q.size(); i++) begin
            cur_i = i;
            x = q[i];
            chk("state", {12'h000, bus.db_estado}, {12'h000, x.st});
            chk("outputs", {4'h0, act_out()}, {4'h0, exp_out(x.st)});
            if (x.game == 8'd0) begin
                dut_ce += int'(bus.contaE);
                dut_cl += int'(bus.contaL);
            end
            reset                   = x.rst;
            bus.iniciar             = x.ini;
            bus.nivel               = x.niv;
            bus.jogada              = x.jog;
            bus.igual               = x.igu;
            bus.timeout             = x.tmo;
            bus.limite              = x.l;
            bus.enderecoIgualLimite = (x.e == x.l);
            bus.fimL                = (x.l == 4'd15);
            bus.fimE                = (x.e == 4'd15);
            @(posedge clock);
            #1;
        end

        chk("dut_contaL_easy", 16'(dut_cl), 16'd7);
        chk("dut_contaE_easy", 16'(dut_ce), 16'd56);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
